instr_loader: RTL and testbench

//  Writer side of instr_mem's write port: drives we/w_addr/w_instr.

---
 rtl/instr_loader_pkg.sv | 23 ++
 rtl/instr_loader.sv | 122 ++++++++++++
 tb/tb_instr_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader_pkg
//  Description : Shared widths and loader FSM state encodings (used with instr_mem)
//  Revision    : 1.0
// ============================================================================
package instr_loader_pkg;

    localparam int c_addr_w  = 8;
    localparam int c_byte_w  = 8;
    localparam int c_instr_w = 2 * c_byte_w;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_len  = 3'd1;
    localparam logic [2:0] c_st_hi   = 3'd2;
    localparam logic [2:0] c_st_lo   = 3'd3;
    localparam logic [2:0] c_st_wr   = 3'd4;
    localparam logic [2:0] c_st_chk  = 3'd5;
    localparam logic [2:0] c_st_done = 3'd6;
    localparam logic [2:0] c_st_err  = 3'd7;

endpackage : instr_loader_pkg
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Framed byte-stream loader writing 16-bit words into instr_mem
//  Revision    : 1.0
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W  = c_addr_w,
    parameter int INSTR_W = c_instr_w,
    parameter int BYTE_W  = c_byte_w
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               we,
    output logic [ADDR_W-1:0]  w_addr,
    output logic [INSTR_W-1:0] w_instr,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               core_rst_n
);

    logic [2:0]        r_state;
    logic [BYTE_W-1:0] r_len;
    logic [BYTE_W-1:0] r_hi;
    logic [BYTE_W-1:0] r_csum;
    logic [ADDR_W-1:0] r_addr;

    logic w_xfer;
    logic w_last;

    // Ready depends on state alone so the host never sees a combinational path from in_valid.
    assign in_ready = (r_state == c_st_len) || (r_state == c_st_hi) ||
                      (r_state == c_st_lo)  || (r_state == c_st_chk);
    assign w_xfer   = in_valid && in_ready;
    assign w_last   = (r_addr == ADDR_W'(r_len - BYTE_W'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_len      <= '0;
            r_hi       <= '0;
            r_csum     <= '0;
            r_addr     <= '0;
            we         <= 1'b0;
            w_addr     <= '0;
            w_instr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_rst_n <= 1'b1;
        end else begin
            we <= 1'b0;
            case (r_state)
                c_st_idle, c_st_done, c_st_err: begin
                    if (start) begin
                        r_state    <= c_st_len;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        core_rst_n <= 1'b0;
                        r_csum     <= '0;
                    end
                end
                c_st_len: begin
                    if (w_xfer) begin
                        r_len   <= in_data;
                        r_addr  <= '0;
                        r_state <= (in_data == '0) ? c_st_chk : c_st_hi;
                    end
                end
                c_st_hi: begin
                    if (w_xfer) begin
                        r_hi    <= in_data;
                        r_csum  <= r_csum ^ in_data;
                        r_state <= c_st_lo;
                    end
                end
                c_st_lo: begin
                    if (w_xfer) begin
                        w_instr <= INSTR_W'({r_hi, in_data});
                        w_addr  <= r_addr;
                        we      <= 1'b1;
                        r_csum  <= r_csum ^ in_data;
                        r_state <= c_st_wr;
                    end
                end
                c_st_wr: begin
                    // Counter stops at N-1, so a 255-word frame never wraps to 0.
                    if (w_last) begin
                        r_state <= c_st_chk;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= c_st_hi;
                    end
                end
                c_st_chk: begin
                    if (w_xfer) begin
                        if (in_data == r_csum) begin
                            done    <= 1'b1;
                            r_state <= c_st_done;
                        end else begin
                            error   <= 1'b1;
                            r_state <= c_st_err;
                        end
                        busy       <= 1'b0;
                        core_rst_n <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule : instr_loader
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Self-checking bench for instr_loader with a frame-level model
//  Revision    : 1.0
// ============================================================================
module tb_instr_loader;
    import instr_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        we;
    logic [7:0]  w_addr;
    logic [15:0] w_instr;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         cap_q[$];
    logic [15:0] mem [256];

    instr_loader #(.ADDR_W(8), .INSTR_W(16), .BYTE_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .we         (we),
        .w_addr     (w_addr),
        .w_instr    (w_instr),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .core_rst_n (core_rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // instr_mem stand-in plus write capture; the write port must be closed while we is high
    always @(negedge clk) begin
        if (rst_n && we) begin
            mem[w_addr] = w_instr;
            cap_q.push_back('{a: w_addr, d: w_instr});
            check("ready_during_wr", {31'd0, in_ready}, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset();
        check("rst_in_ready",   {31'd0, in_ready},   32'd0);
        check("rst_we",         {31'd0, we},         32'd0);
        check("rst_w_addr",     {24'd0, w_addr},     32'd0);
        check("rst_w_instr",    {16'd0, w_instr},    32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_error",      {31'd0, error},      32'd0);
        check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        start    = with_start;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("xfer_timeout", t, 0);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",     {31'd0, busy},       32'd1);
        check("start_core_rst", {31'd0, core_rst_n}, 32'd0);
        check("start_done_clr", {31'd0, done},       32'd0);
        check("start_err_clr",  {31'd0, error},      32'd0);
    endtask

    function automatic int pick_gap(input int gmin, input int gmax);
        return (gmax > gmin) ? int'($urandom_range(gmax, gmin)) : gmin;
    endfunction

    // Frame-level model: word i lands at address i, done iff CHK equals XOR of data bytes.
    task automatic run_frame(input logic [15:0] words[$], input logic [7:0] chk,
                             input int gmin, input int gmax, input bit poke);
        logic [7:0] x;
        bit         exp_ok;
        x = 8'h00;
        foreach (words[i]) x = x ^ words[i][15:8] ^ words[i][7:0];
        exp_ok = (chk == x);
        cap_q.delete();
        start_load();
        send_byte(8'(words.size()), pick_gap(gmin, gmax), 1'b0);
        foreach (words[i]) begin
            send_byte(words[i][15:8], pick_gap(gmin, gmax), poke);
            send_byte(words[i][7:0],  pick_gap(gmin, gmax), 1'b0);
        end
        send_byte(chk, pick_gap(gmin, gmax), poke);
        check("end_done",     {31'd0, done},       {31'd0, exp_ok});
        check("end_error",    {31'd0, error},      {31'd0, !exp_ok});
        check("end_busy",     {31'd0, busy},       32'd0);
        check("end_core_rst", {31'd0, core_rst_n}, 32'd1);
        check("end_in_ready", {31'd0, in_ready},   32'd0);
        check("wr_count",     cap_q.size(),        words.size());
        foreach (cap_q[i]) begin
            if (i < words.size()) begin
                check("wr_addr", {24'd0, cap_q[i].a}, i);
                check("wr_data", {16'd0, cap_q[i].d}, {16'd0, words[i]});
            end
        end
    endtask

    initial begin
        logic [15:0] w1[$];
        logic [15:0] w0[$];
        logic [15:0] wr[$];
        logic [7:0]  x;
        logic [7:0]  c;
        int          n;

        w1 = '{16'h1234, 16'hABCD};
        w0 = {};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, then readback through the memory model
        run_frame(w1, 8'h40, 0, 0, 1'b0);
        check("mem0", {16'd0, mem[0]}, 32'h1234);
        check("mem1", {16'd0, mem[1]}, 32'hABCD);

        // Bad checksum: writes still happen
        run_frame(w1, 8'h41, 0, 0, 1'b0);

        // Empty frames
        run_frame(w0, 8'h00, 0, 0, 1'b0);
        run_frame(w0, 8'hFF, 0, 0, 1'b0);

        // Three idle cycles between every byte
        run_frame(w1, 8'h40, 3, 3, 1'b0);

        // Reset after the third byte
        start_load();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset();
        // Start coinciding with reset
        start = 1'b1;
        @(negedge clk);
        check_reset();
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(w1, 8'h40, 0, 1, 1'b0);

        // start pulsed during the load must not disturb it
        run_frame(w1, 8'h40, 0, 2, 1'b1);

        // Randomized frames, one in four with a corrupted checksum
        for (int f = 0; f < 30; f++) begin
            n = int'($urandom_range(12, 0));
            wr = {};
            x = 8'h00;
            for (int k = 0; k < n; k++) begin
                wr.push_back(16'($urandom));
                x = x ^ wr[k][15:8] ^ wr[k][7:0];
            end
            c = x;
            if ($urandom_range(3, 0) == 0) c = x ^ 8'(int'($urandom_range(255, 1)));
            run_frame(wr, c, 0, 3, 1'($urandom_range(1, 0)));
        end

        // Largest frame: addresses 0..254, no wrap
        wr = {};
        x = 8'h00;
        for (int k = 0; k < 255; k++) begin
            wr.push_back(16'($urandom));
            x = x ^ wr[k][15:8] ^ wr[k][7:0];
        end
        run_frame(wr, x, 0, 0, 1'b0);
        check("mem254", {16'd0, mem[254]}, {16'd0, wr[254]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_loader
`default_nettype wire
